// File: rtl/uart_rx_frontend_if.sv
// uart_rx_frontend_if
//   Receiver-to-RX-FIFO handshake bundle.
//   i_rx_full    FIFO full indication (FIFO -> receiver)
//   o_rx_push    single-cycle push strobe into the FIFO
//   o_rx_data    received byte, valid while o_rx_push is high
//   o_overrun    single-cycle pulse: good byte dropped because the FIFO was full
//   o_frame_err  single-cycle pulse: stop bit low on a non-zero frame
//   modport master : receiver side
//   modport slave  : FIFO side
interface uart_rx_frontend_if;
   logic       i_rx_full;
   logic       o_rx_push;
   logic [7:0] o_rx_data;
   logic       o_overrun;
   logic       o_frame_err;

   modport master (
      input  i_rx_full,
      output o_rx_push,
      output o_rx_data,
      output o_overrun,
      output o_frame_err
   );

   modport slave (
      output i_rx_full,
      input  o_rx_push,
      input  o_rx_data,
      input  o_overrun,
      input  o_frame_err
   );
endinterface

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend
//   8N1 UART receive front end: synchronises the raw RX line, detects a start
//   edge, samples the start bit at mid-bit and every following bit one bit
//   period later, then pushes the byte into the RX FIFO or reports overrun,
//   framing error or break.
//   Ports:
//     i_clk       system clock (rising edge)
//     i_rst_n     asynchronous active-low reset
//     i_uart_rxd  raw serial line, asynchronous, idle high
//     i_enable    receiver enable
//     fifo        FIFO handshake (uart_rx_frontend_if.master)
//     o_break     level: break condition in progress
//     o_busy      level: FSM not idle
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a falling edge on the synchronised line
//   START | timing to the middle of the start bit, rejecting glitches
//   DATA  | sampling 8 data bits LSB-first, one per bit period
//   STOP  | sampling the stop bit and reporting the frame outcome
//   BRK   | all-zero frame with low stop bit; wait for the line to rise
module uart_rx_frontend #(
   parameter int CLKS_PER_BIT = 174
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_uart_rxd,
   input  logic                      i_enable,
   uart_rx_frontend_if.master        fifo,
   output logic                      o_break,
   output logic                      o_busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BRK
   } state_t;

   state_t          state;
   logic [CW-1:0]   bit_cnt;
   logic [2:0]      idx;
   logic [7:0]      shreg;
   logic            rxd_m;
   logic            rxd_s;
   logic            rxd_p;

   // Line idles high, so the synchroniser resets high to avoid a false start
   // edge right after reset release.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rxd_m <= 1'b1;
         rxd_s <= 1'b1;
         rxd_p <= 1'b1;
      end else begin
         rxd_m <= i_uart_rxd;
         rxd_s <= rxd_m;
         rxd_p <= rxd_s;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state            <= S_IDLE;
         bit_cnt          <= '0;
         idx              <= '0;
         shreg            <= '0;
         fifo.o_rx_push   <= 1'b0;
         fifo.o_rx_data   <= '0;
         fifo.o_overrun   <= 1'b0;
         fifo.o_frame_err <= 1'b0;
         o_break          <= 1'b0;
      end else begin
         fifo.o_rx_push   <= 1'b0;
         fifo.o_overrun   <= 1'b0;
         fifo.o_frame_err <= 1'b0;
         if (!i_enable) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            idx     <= '0;
            o_break <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (rxd_p && !rxd_s) begin
                     state   <= S_START;
                     bit_cnt <= '0;
                  end
               end
               S_START: begin
                  if (bit_cnt == HALF_LAST) begin
                     bit_cnt <= '0;
                     idx     <= '0;
                     state   <= rxd_s ? S_IDLE : S_DATA;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               S_DATA: begin
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
                     shreg   <= {rxd_s, shreg[7:1]};
                     idx     <= idx + 1'b1;
                     if (idx == 3'd7) begin
                        state <= S_STOP;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               S_STOP: begin
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
                     if (rxd_s) begin
                        // Byte is captured even when dropped, so software can
                        // still inspect what was lost on overrun.
                        fifo.o_rx_data <= shreg;
                        if (fifo.i_rx_full) begin
                           fifo.o_overrun <= 1'b1;
                        end else begin
                           fifo.o_rx_push <= 1'b1;
                        end
                        state <= S_IDLE;
                     end else if (shreg != 8'h00) begin
                        fifo.o_frame_err <= 1'b1;
                        state            <= S_IDLE;
                     end else begin
                        o_break <= 1'b1;
                        state   <= S_BRK;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               S_BRK: begin
                  if (rxd_s) begin
                     o_break <= 1'b0;
                     state   <= S_IDLE;
                  end
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign o_busy = (state != S_IDLE);

endmodule

// File: doc/uart_rx_frontend.md
UART_RX_FRONTEND -- requirements
Module: uart_rx_frontend

Interface
REQ-001 Parameter CLKS_PER_BIT, default 174, meaning i_clk cycles per UART bit period; legal range 4..1023.
REQ-002 Clock and reset are fixed: one clock, i_clk, and reset i_rst_n, which is asynchronous and active-low.
REQ-003 Port i_clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port i_rst_n  input  1  asynchronous active-low reset.
REQ-005 Port i_uart_rxd  input  1  raw serial receive line, asynchronous to i_clk, idle high.
REQ-006 Port i_enable  input  1  receiver enable, from the UART control register.
REQ-007 Port i_rx_full  input  1  downstream RX FIFO full indication.
REQ-008 Port o_rx_push  output  1  single-cycle push strobe into the RX FIFO.
REQ-009 Port o_rx_data  output  8  received byte, valid when o_rx_push is high.
REQ-010 Port o_overrun  output  1  single-cycle pulse: valid byte dropped because i_rx_full was high.
REQ-011 Port o_frame_err  output  1  single-cycle pulse: stop bit sampled low on a non-zero frame.
REQ-012 Port o_break  output  1  level: break condition in progress.
REQ-013 Port o_busy  output  1  level: FSM is not in IDLE.

Function
REQ-014 i_uart_rxd SHALL pass through a 2-flop synchroniser (reset value 1); rxd_s denotes the second flop, and rxd_p denotes its value registered one cycle later.
REQ-015 The FSM SHALL have the states IDLE, START, DATA, STOP and BRK, with a bit counter bit_cnt (0..CLKS_PER_BIT-1) and a data index idx (0..7).
REQ-016 IDLE: when i_enable=1, rxd_p=1 and rxd_s=0 (falling edge), the FSM SHALL go to START with bit_cnt=0.
REQ-017 START: when bit_cnt reaches floor(CLKS_PER_BIT/2)-1, rxd_s SHALL be sampled; 1 -> IDLE (false start, no output pulse); 0 -> DATA with bit_cnt=0 and idx=0.
REQ-018 DATA: when bit_cnt reaches CLKS_PER_BIT-1, rxd_s SHALL be shifted in LSB-first and bit_cnt cleared; the FSM SHALL leave for STOP after the sample with idx=7.
REQ-019 STOP: when bit_cnt reaches CLKS_PER_BIT-1, the stop bit SHALL be sampled.
REQ-020 Stop bit 1 and i_rx_full=0: o_rx_push SHALL pulse for one cycle on the next cycle, with o_rx_data equal to the assembled byte; the FSM returns to IDLE.
REQ-021 Stop bit 1 and i_rx_full=1 at the sample cycle: there SHALL be no push and o_overrun SHALL pulse for one cycle; o_rx_data is still updated.
REQ-022 Stop bit 0 and byte non-zero: o_frame_err SHALL pulse for one cycle, there is no push, and the FSM goes to IDLE; a new start requires a fresh falling edge.
REQ-023 Stop bit 0 and byte 0x00: the FSM SHALL go to BRK with o_break=1 and no push; o_break deasserts and the FSM goes to IDLE on the first cycle rxd_s=1.
REQ-024 i_enable=0 in any state SHALL force IDLE on the next edge and clear bit_cnt, idx and o_break; a partial frame is discarded with no pulses.
REQ-025 o_rx_data SHALL hold its last value between frames.
REQ-026 At most one of o_rx_push, o_overrun and o_frame_err SHALL be high in any cycle.
REQ-027 o_busy SHALL be 1 in every state except IDLE.
REQ-028 Latency: the push pulse SHALL occur exactly 1 cycle after the stop-bit sample cycle.

Reset
REQ-029 While i_rst_n=0: state=IDLE, bit_cnt=0, idx=0, the synchroniser flops and rxd_p =1, and every output =0 (o_rx_data=0x00).
REQ-030 Reset assertion mid-frame SHALL abort the frame immediately; after release, the FSM needs a new falling edge to start.

Verification (bench uses CLKS_PER_BIT=16, i_enable=1 unless stated)
REQ-031 Send 8N1 frame 0xA5 with i_rx_full=0 -> one o_rx_push pulse with o_rx_data=0xA5; no o_frame_err or o_overrun.
REQ-032 Send 0x3C with i_rx_full=1 -> o_overrun pulses once, no push, o_rx_data=0x3C.
REQ-033 Drive rxd low for 5 cycles, then high -> START aborts to IDLE; no output pulses; o_busy low again within 9 cycles.
REQ-034 Send 0x81 with the stop bit driven low -> o_frame_err pulses once, no push; a following valid 0x42 -> push with 0x42.
REQ-035 Hold rxd low for 12 bit times, then release -> o_break rises after the stop sample and falls 1 cycle after rxd_s=1; no push.
REQ-036 Drop i_enable mid-DATA of 0xFF, then re-enable and send 0x11 -> exactly one push with 0x11 and no other pulses.
